// File: rtl/irq_ctrl_pkg.sv
// ============================================================================
// Module   : irq_ctrl_pkg
// Brief    : Register map and cause-encoding constants for irq_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package irq_ctrl_pkg;

    localparam logic [1:0] IRQ_PEND      = 2'd0;
    localparam logic [1:0] IRQ_ENABLE    = 2'd1;
    localparam logic [1:0] IRQ_CAUSE     = 2'd2;
    localparam logic [1:0] IRQ_SWSET     = 2'd3;

    localparam int         CAUSE_VALID   = 15;
    localparam logic [3:0] SPURIOUS_CODE = 4'hF;

endpackage

`default_nettype wire

// File: rtl/irq_sync_edge.sv
// ============================================================================
// Module   : irq_sync_edge
// Brief    : Per-source 2-FF synchronizer with edge or level event generation.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_sync_edge #(
    parameter int           W         = 8,
    parameter logic [W-1:0] EDGE_MASK = {W{1'b1}}
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] src_i,
    output logic [W-1:0] evt_o
);

    logic [W-1:0] s1_q;
    logic [W-1:0] s2_q;
    logic [W-1:0] s3_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= src_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // Edge sources fire once per rising edge; level sources fire while high.
    assign evt_o = (s2_q & ~s3_q & EDGE_MASK) | (s2_q & ~EDGE_MASK);

endmodule

`default_nettype wire

// File: rtl/irq_ctrl.sv
// ============================================================================
// Module   : irq_ctrl
// Brief    : Fixed-priority interrupt controller with memory-mapped registers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int              NSRC      = 8,
    parameter logic [NSRC-1:0] EDGE_MASK = {NSRC{1'b1}}
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] src,
    input  logic            ien,
    input  logic            irq_ack,
    output logic            irq,
    input  logic [1:0]      addr,
    input  logic [15:0]     wdata,
    input  logic            wen,
    input  logic            ren,
    output logic [15:0]     rdata
);

    logic [NSRC-1:0] w_evt;
    logic [NSRC-1:0] w_act;
    logic [NSRC-1:0] w_sw_set;
    logic [NSRC-1:0] w_w1c;
    logic [NSRC-1:0] w_ack_clr;
    logic [3:0]      w_sel;
    logic            w_none;

    logic [NSRC-1:0] pend_q,      pend_d;
    logic [NSRC-1:0] enable_q,    enable_d;
    logic            cause_vld_q, cause_vld_d;
    logic [3:0]      cause_code_q, cause_code_d;
    logic            irq_q;
    logic [15:0]     rdata_q,     rdata_d;

    logic            unused_wdata;
    assign unused_wdata = ^wdata[15:NSRC];

    irq_sync_edge #(
        .W         (NSRC),
        .EDGE_MASK (EDGE_MASK)
    ) u_sync (
        .clk   (clk),
        .rst   (rst),
        .src_i (src),
        .evt_o (w_evt)
    );

    assign w_act = pend_q & enable_q;

    // Lowest index wins; scan downwards so the last hit is the lowest bit.
    always_comb begin
        w_sel = SPURIOUS_CODE;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (w_act[i]) w_sel = 4'(i);
        end
        w_none = (w_act == '0);
    end

    always_comb begin
        w_sw_set  = (wen && addr == IRQ_SWSET) ? wdata[NSRC-1:0] : '0;
        w_w1c     = (wen && addr == IRQ_PEND)  ? wdata[NSRC-1:0] : '0;
        w_ack_clr = (irq_ack && !w_none) ? (NSRC'(1) << w_sel) : '0;

        // Set terms are OR'd after the clear so a coincident event survives.
        pend_d   = w_evt | w_sw_set | (pend_q & ~(w_w1c | w_ack_clr));
        enable_d = (wen && addr == IRQ_ENABLE) ? wdata[NSRC-1:0] : enable_q;

        cause_vld_d  = cause_vld_q;
        cause_code_d = cause_code_q;
        if (irq_ack) begin
            cause_vld_d  = 1'b1;
            cause_code_d = w_none ? SPURIOUS_CODE : w_sel;
        end else if (wen && addr == IRQ_CAUSE) begin
            cause_vld_d  = 1'b0;
        end

        rdata_d = rdata_q;
        if (ren) begin
            case (addr)
                IRQ_PEND:   rdata_d = {{(16-NSRC){1'b0}}, pend_q};
                IRQ_ENABLE: rdata_d = {{(16-NSRC){1'b0}}, enable_q};
                IRQ_CAUSE:  rdata_d = {cause_vld_q, 11'b0, cause_code_q};
                default:    rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q       <= '0;
            enable_q     <= '0;
            cause_vld_q  <= 1'b0;
            cause_code_q <= '0;
            irq_q        <= 1'b0;
            rdata_q      <= '0;
        end else begin
            pend_q       <= pend_d;
            enable_q     <= enable_d;
            cause_vld_q  <= cause_vld_d;
            cause_code_q <= cause_code_d;
            irq_q        <= ien & ~w_none;
            rdata_q      <= rdata_d;
        end
    end

    assign irq   = irq_q;
    assign rdata = rdata_q;

endmodule

`default_nettype wire
